// File: rtl/ifetch_axi_master.sv
// rtl/ifetch_axi_master.sv - instruction fetch initiator on an AXI-style read channel with decode FIFO (optional IFETCH_STAT_EN counters)
module ifetch_axi_master #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 4,
   parameter int          ADDR_SHIFT = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        arvalid,
   output logic [31:0] araddr,
   output logic [1:0]  arburst,
   output logic [2:0]  arsize,
   output logic [7:0]  arlen,
   input  logic        arready,
   input  logic        rvalid,
   input  logic [31:0] rdata,
   input  logic        rlast,
   output logic        rready,
   output logic        inst_valid,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
`ifdef IFETCH_STAT_EN
   output logic [31:0] stat_fetched,
   output logic [31:0] stat_dropped,
`endif
   input  logic        inst_ready
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_AR   = 2'd1;
   localparam logic [1:0] S_R    = 2'd2;

   logic [1:0]    state;
   logic [31:0]   pc;
   logic [31:0]   req_pc;
   logic          stale;
   logic [31:0]   fifo_data [FIFO_DEPTH];
   logic [31:0]   fifo_pc   [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;
   logic          has_space;
   logic          beat;
   logic          push;
   logic          pop;
   logic [31:0]   redir_pc_al;
   logic [31:0]   fetch_pc;
   logic          unused;

   // Single-beat word reads only; rlast and the redirect byte offset carry no information.
   assign arburst = 2'b01;
   assign arsize  = 3'b010;
   assign arlen   = 8'd0;
   assign unused  = ^{rlast, redirect_pc[1:0]};

   assign redir_pc_al = {redirect_pc[31:2], 2'b00};
   // A redirect arriving in the same cycle as an issue decision wins over the held PC.
   assign fetch_pc    = redirect_valid ? redir_pc_al : pc;
   assign beat        = (state == S_R) && rvalid;
   assign push        = beat && !stale && !redirect_valid;
   assign pop         = inst_valid && inst_ready && !redirect_valid;

   assign inst_valid  = (count != '0);
   assign inst_data   = fifo_data[rd_ptr];
   assign inst_pc     = fifo_pc[rd_ptr];

   // Occupancy after this cycle decides whether another request may be issued.
   always_comb begin
      count_next = count;
      if (redirect_valid)
         count_next = '0;
      else
         count_next = count + CW'(push) - CW'(pop);
      has_space = (count_next < CW'(FIFO_DEPTH));
   end

   // Fetch control: issue, address handshake, data beat, stale tracking.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         pc      <= RESET_PC;
         req_pc  <= RESET_PC;
         arvalid <= 1'b0;
         araddr  <= '0;
         rready  <= 1'b0;
         stale   <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (redirect_valid)
                  pc <= redir_pc_al;
               if (has_space) begin
                  araddr  <= fetch_pc >> ADDR_SHIFT;
                  req_pc  <= fetch_pc;
                  arvalid <= 1'b1;
                  state   <= S_AR;
               end
            end
            S_AR: begin
               // The address already on the bus cannot be withdrawn; its data is marked stale.
               if (redirect_valid) begin
                  pc    <= redir_pc_al;
                  stale <= 1'b1;
               end
               if (arready) begin
                  arvalid <= 1'b0;
                  rready  <= 1'b1;
                  state   <= S_R;
                  if (!redirect_valid && !stale)
                     pc <= pc + 32'd4;
               end
            end
            S_R: begin
               if (rvalid) begin
                  stale <= 1'b0;
                  if (redirect_valid)
                     pc <= redir_pc_al;
                  if (has_space) begin
                     araddr  <= fetch_pc >> ADDR_SHIFT;
                     req_pc  <= fetch_pc;
                     arvalid <= 1'b1;
                     rready  <= 1'b0;
                     state   <= S_AR;
                  end else begin
                     rready <= 1'b0;
                     state  <= S_IDLE;
                  end
               end else if (redirect_valid) begin
                  pc    <= redir_pc_al;
                  stale <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // FIFO pointers and occupancy; a redirect empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_valid) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PW'(1);
         if (pop)
            rd_ptr <= rd_ptr + PW'(1);
         count <= count_next;
      end
   end

   // FIFO storage holds each returned word alongside the PC it was fetched from.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= rdata;
         fifo_pc[wr_ptr]   <= req_pc;
      end
   end

`ifdef IFETCH_STAT_EN
   // Fetched counts accepted beats; dropped counts stale beats and beats killed by a redirect.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_fetched <= '0;
         stat_dropped <= '0;
      end else begin
         if (push)
            stat_fetched <= stat_fetched + 32'd1;
         if (beat && (stale || redirect_valid))
            stat_dropped <= stat_dropped + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ifetch_axi_master.sv
// tb/tb_ifetch_axi_master.sv - self-checking bench for ifetch_axi_master
module tb_ifetch_axi_master;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        arvalid;
   logic [31:0] araddr;
   logic [1:0]  arburst;
   logic [2:0]  arsize;
   logic [7:0]  arlen;
   logic        arready = 1'b0;
   logic        rvalid = 1'b0;
   logic [31:0] rdata = '0;
   logic        rlast = 1'b1;
   logic        rready;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready = 1'b0;
`ifdef IFETCH_STAT_EN
   logic [31:0] stat_fetched;
   logic [31:0] stat_dropped;
`endif

   always #5 clk = ~clk;

   ifetch_axi_master #(.RESET_PC(32'h0), .FIFO_DEPTH(4), .ADDR_SHIFT(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .arvalid(arvalid), .araddr(araddr), .arburst(arburst), .arsize(arsize), .arlen(arlen),
      .arready(arready), .rvalid(rvalid), .rdata(rdata), .rlast(rlast), .rready(rready),
      .inst_valid(inst_valid), .inst_data(inst_data), .inst_pc(inst_pc),
`ifdef IFETCH_STAT_EN
      .stat_fetched(stat_fetched), .stat_dropped(stat_dropped),
`endif
      .inst_ready(inst_ready)
   );

   typedef struct {
      logic [31:0] rpc;
      logic [31:0] exp_araddr;
      logic [31:0] exp_pc0;
      logic [31:0] exp_pc1;
   } vec_t;

   int checks = 0;
   int errors = 0;
   int ar_gap = 0;
   int r_delay = 0;
   int ar_wait = 0;
   int r_wait = 0;
   bit pend = 0;
   logic [31:0] pend_addr = '0;
   logic [31:0] ar_log[$];
   logic [31:0] exp_q[$];
   logic [31:0] pop_log[$];

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return 32'h1357_9BDF ^ (a * 32'h9E37_79B1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic expect_seq(input logic [31:0] base, input int n);
      exp_q.delete();
      for (int k = 0; k < n; k++) exp_q.push_back(base + 32'(4 * k));
   endtask

   // One clock: sample handshakes before the edge, then update scoreboard and responder.
   task automatic step();
      bit ar_f, r_f, pop_f;
      logic [31:0] aa, hp, hd, e;
      ar_f  = arvalid && arready;
      aa    = araddr;
      r_f   = rvalid && rready;
      pop_f = inst_valid && inst_ready && !redirect_valid;
      hp    = inst_pc;
      hd    = inst_data;
      @(posedge clk);
      #1;
      redirect_valid = 1'b0;
      if (pop_f) begin
         pop_log.push_back(hp);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h, expected no pop", hp);
         end else begin
            e = exp_q.pop_front();
            chk("pop_pc", hp, e);
            chk("pop_data", hd, mem_word(e >> 2));
         end
      end
      if (r_f) rvalid = 1'b0;
      if (ar_f) begin
         ar_log.push_back(aa);
         pend = 1;
         pend_addr = aa;
         r_wait = r_delay;
         ar_wait = 0;
      end
      if (arvalid) begin
         arready = (ar_wait >= ar_gap);
         ar_wait++;
      end else begin
         arready = 1'b0;
         ar_wait = 0;
      end
      if (pend && !rvalid) begin
         if (r_wait == 0) begin
            rvalid = 1'b1;
            rdata = mem_word(pend_addr);
            pend = 0;
         end else begin
            r_wait--;
         end
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      redirect_valid = 1'b0;
      arready = 1'b0;
      rvalid = 1'b0;
      pend = 0;
      ar_wait = 0;
      exp_q.delete();
      ar_log.delete();
      pop_log.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic run_pops(input int n, input string name);
      int b;
      b = 0;
      while (pop_log.size() < n && b < 80) begin
         step();
         b++;
      end
      if (pop_log.size() < n) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d pops, expected %0d", name, pop_log.size(), n);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      vec_t vecs[4];
      int n, b;
      logic [31:0] d0;
      vecs[0] = '{32'h0000_0100, 32'h0000_0040, 32'h0000_0100, 32'h0000_0104};
      vecs[1] = '{32'h0000_0203, 32'h0000_0080, 32'h0000_0200, 32'h0000_0204};
      vecs[2] = '{32'hFFFF_FFFE, 32'h3FFF_FFFF, 32'hFFFF_FFFC, 32'h0000_0000};
      vecs[3] = '{32'h0000_1001, 32'h0000_0400, 32'h0000_1000, 32'h0000_1004};

      // Reset state and first request latency
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_arvalid", 32'(arvalid), 0);
      chk("rst_rready", 32'(rready), 0);
      chk("rst_inst_valid", 32'(inst_valid), 0);
      chk("rst_araddr", araddr, 0);
      chk("const_ar", {19'd0, arburst, arsize, arlen}, {19'd0, 2'b01, 3'b010, 8'd0});
`ifdef IFETCH_STAT_EN
      chk("rst_stat_fetched", stat_fetched, 0);
      chk("rst_stat_dropped", stat_dropped, 0);
`endif
      ar_gap = 0;
      r_delay = 0;
      inst_ready = 1'b1;
      do_reset();
      expect_seq(32'h0, 64);
      step();
      chk("first_arvalid", 32'(arvalid), 1);
      chk("first_araddr", araddr, 0);

      // Zero-wait streaming
      repeat (20) step();
      for (int k = 0; k < 4; k++) chk("stream_araddr", ar_log[k], 32'(k));
      for (int k = 0; k < 4; k++) chk("stream_pc", pop_log[k], 32'(4 * k));
      n = ar_log.size();
      repeat (20) step();
      chk("stream_rate", 32'(ar_log.size() - n), 10);

      // Backpressure: FIFO fills, fetch stops, then resumes at pc 16
      do_reset();
      inst_ready = 1'b0;
      expect_seq(32'h0, 64);
      repeat (30) step();
      chk("full_ar_count", 32'(ar_log.size()), 4);
      chk("full_arvalid", 32'(arvalid), 0);
      chk("full_inst_valid", 32'(inst_valid), 1);
      inst_ready = 1'b1;
      repeat (20) step();
      chk("resume_araddr", ar_log[4], 32'd4);
      chk("resume_pc", pop_log[4], 32'd16);

      // Stalled address phase keeps arvalid/araddr stable
      do_reset();
      inst_ready = 1'b0;
      ar_gap = 3;
      step();
      for (int k = 0; k < 3; k++) begin
         chk("stall_arvalid", 32'(arvalid), 1);
         chk("stall_araddr", araddr, 0);
         chk("stall_ar_count", 32'(ar_log.size()), 0);
         step();
      end
      expect_seq(32'h0, 64);
      step();
      chk("stall_hs_count", 32'(ar_log.size()), 1);
      chk("stall_hs_rready", 32'(rready), 1);

      // Redirect during stalled address phase: old address held, pc not advanced
      do_reset();
      inst_ready = 1'b1;
      ar_gap = 3;
      step();
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      expect_seq(32'h300, 64);
      step();
      chk("ar_redir_arvalid", 32'(arvalid), 1);
      chk("ar_redir_araddr", araddr, 0);
      run_pops(2, "ar_redir");
      chk("ar_redir_log0", ar_log[0], 0);
      chk("ar_redir_log1", ar_log[1], 32'h0000_00C0);
      chk("ar_redir_log2", ar_log[2], 32'h0000_00C1);
      ar_gap = 0;

      // Redirect while waiting for rvalid
      do_reset();
      r_delay = 3;
      expect_seq(32'h0, 64);
      b = 0;
      step();
      while (!(rready && !rvalid) && b < 20) begin
         step();
         b++;
      end
      chk("wait_r_state", 32'(rready && !rvalid), 1);
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0100;
      expect_seq(32'h100, 64);
      pop_log.delete();
      step();
      n = ar_log.size();
      chk("r_redir_empty", 32'(inst_valid), 0);
      run_pops(1, "r_redir");
      chk("r_redir_araddr", ar_log[n], 32'h0000_0040);
      chk("r_redir_pc", pop_log[0], 32'h0000_0100);
      r_delay = 0;

      // Redirect coinciding with the data beat and a pop
      do_reset();
      inst_ready = 1'b0;
      expect_seq(32'h0, 64);
      repeat (5) step();
      inst_ready = 1'b1;
      b = 0;
      while (!(rvalid && rready && inst_valid) && b < 20) begin
         step();
         b++;
      end
      chk("beat_pop_cond", 32'(rvalid && rready && inst_valid), 1);
`ifdef IFETCH_STAT_EN
      d0 = stat_dropped;
`else
      d0 = '0;
`endif
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0200;
      expect_seq(32'h200, 64);
      pop_log.delete();
      step();
      n = ar_log.size();
      chk("beat_redir_empty", 32'(inst_valid), 0);
`ifdef IFETCH_STAT_EN
      chk("beat_redir_dropped", stat_dropped, d0 + 32'd1);
`endif
      run_pops(1, "beat_redir");
      chk("beat_redir_araddr", ar_log[n], 32'h0000_0080);
      chk("beat_redir_pc", pop_log[0], 32'h0000_0200);

      // Table of redirect targets at varying phases
      do_reset();
      inst_ready = 1'b1;
      expect_seq(32'h0, 64);
      repeat (6) step();
      for (int i = 0; i < 4; i++) begin
         repeat (i % 3) step();
         redirect_valid = 1'b1;
         redirect_pc = vecs[i].rpc;
         expect_seq(vecs[i].exp_pc0, 32);
         pop_log.delete();
         step();
         n = ar_log.size();
         chk("vec_empty", 32'(inst_valid), 0);
         run_pops(2, "vec");
         chk("vec_araddr", ar_log[n], vecs[i].exp_araddr);
         chk("vec_pc0", pop_log[0], vecs[i].exp_pc0);
         chk("vec_pc1", pop_log[1], vecs[i].exp_pc1);
      end

      // Asynchronous reset in the middle of an address phase
      do_reset();
      ar_gap = 3;
      step();
      step();
      chk("mid_ar_arvalid", 32'(arvalid), 1);
      rst_n = 1'b0;
      #1;
      chk("async_arvalid", 32'(arvalid), 0);
      chk("async_rready", 32'(rready), 0);
      chk("async_inst_valid", 32'(inst_valid), 0);
      ar_gap = 0;
      do_reset();
      expect_seq(32'h0, 64);
      step();
      chk("post_rst_arvalid", 32'(arvalid), 1);
      chk("post_rst_araddr", araddr, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
